draw_bug_rect: RTL and testbench



---
 rtl/draw_bug_rect.sv | 177 +++++++++++++++++
 tb/tb_draw_bug_rect.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/draw_bug_rect.sv
// draw_bug_rect: overlays a rotated bug sprite from a synchronous ROM onto
// the VGA pixel stream. Timing signals and rgb are delayed by 3 pixel clocks.
// Bug position/rotation are latched on the vblank rising edge.
// Optional build macro: BUG_TRANSPARENT_EN (pixels equal to KEY_COLOR show
// the background instead of the sprite).
module draw_bug_rect #(
  parameter int unsigned BUG_W     = 53,
  parameter int unsigned BUG_H     = 54,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [10:0]       hcount_in,
  input  logic [10:0]       vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              hblnk_in,
  input  logic              vblnk_in,
  input  logic [11:0]       rgb_in,
  input  logic [11:0]       xpos,
  input  logic [11:0]       ypos,
  input  logic [1:0]        rotation,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [10:0]       hcount_out,
  output logic [10:0]       vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              hblnk_out,
  output logic              vblnk_out,
  output logic [11:0]       rgb_out
);

  // 13-bit geometry so a sprite near 4095 cannot wrap into column 0
  localparam int unsigned CW = 13;

`ifdef BUG_TRANSPARENT_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif

  logic          vblnk_prev;
  logic [11:0]   x_l;
  logic [11:0]   y_l;
  logic [1:0]    rot_l;

  logic [CW-1:0] hc_c, vc_c, xl_c, yl_c, dx_c, dy_c, fw_c, fh_c;
  logic [CW-1:0] col_c, row_c;
  logic          in_box_c;
  logic [ADDR_W-1:0] addr_c;

  logic [10:0]   h_d1, v_d1, h_d2, v_d2;
  logic          hs_d1, vs_d1, hb_d1, vb_d1, in_box_d1;
  logic          hs_d2, vs_d2, hb_d2, vb_d2, in_box_d2;
  logic [11:0]   rgb_d1, rgb_d2;
  logic          key_hit_c;

  // Frame latch: capture position/rotation once per frame on vblank rise
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev <= 1'b0;
      x_l        <= '0;
      y_l        <= '0;
      rot_l      <= '0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        x_l   <= xpos;
        y_l   <= ypos;
        rot_l <= rotation;
      end
    end
  end

  // Box test and rotated sprite address for the current pixel
  always_comb begin
    hc_c = CW'(hcount_in);
    vc_c = CW'(vcount_in);
    xl_c = CW'(x_l);
    yl_c = CW'(y_l);
    dx_c = hc_c - xl_c;
    dy_c = vc_c - yl_c;
    fw_c = rot_l[0] ? CW'(BUG_H) : CW'(BUG_W);
    fh_c = rot_l[0] ? CW'(BUG_W) : CW'(BUG_H);
    in_box_c = (hc_c >= xl_c) && (hc_c < xl_c + fw_c) &&
               (vc_c >= yl_c) && (vc_c < yl_c + fh_c);
    col_c = dx_c;
    row_c = dy_c;
    case (rot_l)
      2'd0: begin col_c = dx_c;                    row_c = dy_c;                    end
      2'd1: begin col_c = CW'(BUG_W - 1) - dy_c;   row_c = dx_c;                    end
      2'd2: begin col_c = CW'(BUG_W - 1) - dx_c;   row_c = CW'(BUG_H - 1) - dy_c;   end
      default: begin col_c = dy_c;                 row_c = CW'(BUG_H - 1) - dx_c;   end
    endcase
    addr_c = in_box_c ? ADDR_W'(row_c * CW'(BUG_W) + col_c) : '0;
  end

  // Stage 1: register ROM address and first delay of the pixel stream
  always_ff @(posedge pclk) begin
    if (rst) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      h_d1      <= '0;
      v_d1      <= '0;
      hs_d1     <= 1'b0;
      vs_d1     <= 1'b0;
      hb_d1     <= 1'b0;
      vb_d1     <= 1'b0;
      rgb_d1    <= '0;
    end else begin
      rom_addr  <= addr_c;
      in_box_d1 <= in_box_c;
      h_d1      <= hcount_in;
      v_d1      <= vcount_in;
      hs_d1     <= hsync_in;
      vs_d1     <= vsync_in;
      hb_d1     <= hblnk_in;
      vb_d1     <= vblnk_in;
      rgb_d1    <= rgb_in;
    end
  end

  // Stage 2: wait for the ROM read latency
  always_ff @(posedge pclk) begin
    if (rst) begin
      in_box_d2 <= 1'b0;
      h_d2      <= '0;
      v_d2      <= '0;
      hs_d2     <= 1'b0;
      vs_d2     <= 1'b0;
      hb_d2     <= 1'b0;
      vb_d2     <= 1'b0;
      rgb_d2    <= '0;
    end else begin
      in_box_d2 <= in_box_d1;
      h_d2      <= h_d1;
      v_d2      <= v_d1;
      hs_d2     <= hs_d1;
      vs_d2     <= vs_d1;
      hb_d2     <= hb_d1;
      vb_d2     <= vb_d1;
      rgb_d2    <= rgb_d1;
    end
  end

  // Transparent colour key only matters when the feature is built in
  assign key_hit_c = KEY_EN && (rom_data == KEY_COLOR);

  // Stage 3: composite sprite over background, blank forces black
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= h_d2;
      vcount_out <= v_d2;
      hsync_out  <= hs_d2;
      vsync_out  <= vs_d2;
      hblnk_out  <= hb_d2;
      vblnk_out  <= vb_d2;
      if (hb_d2 || vb_d2)
        rgb_out <= 12'h000;
      else if (in_box_d2 && !key_hit_c)
        rgb_out <= rom_data;
      else
        rgb_out <= rgb_d2;
    end
  end

endmodule

// File: tb/tb_draw_bug_rect.sv
// Directed bench for draw_bug_rect with a synchronous ROM model.
module tb_draw_bug_rect;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;
  logic [1:0]  rotation = '0;
  logic [11:0] rom_addr;
  logic [11:0] rom_data = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int n_cmp = 0;
  int n_err = 0;

  draw_bug_rect dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .rotation(rotation),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  // ROM contents: address xor a constant, so 0xAAA holds 0xF0F
  function automatic logic [11:0] rom_word(input logic [11:0] a);
    return a ^ 12'h5A5;
  endfunction

  // Synchronous ROM: data one clock after address
  always @(posedge pclk) rom_data <= rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Produce a vblank rising edge so the DUT latches x/y/rotation
  task automatic latch_frame(input logic [11:0] x, input logic [11:0] y, input logic [1:0] r);
    xpos = x; ypos = y; rotation = r;
    vblnk_in = 1'b0;
    @(posedge pclk); #1;
    vblnk_in = 1'b1;
    @(posedge pclk); #1;
    vblnk_in = 1'b0;
    @(posedge pclk); #1;
  endtask

  // Apply one pixel, check rom_addr after 1 clock and outputs after 3
  task automatic px(input string tag, input logic [10:0] h, input logic [10:0] v,
                    input logic [11:0] rgb, input logic hb,
                    input logic [11:0] ea, input logic [11:0] er);
    hcount_in = h; vcount_in = v; rgb_in = rgb; hblnk_in = hb; vblnk_in = 1'b0;
    @(posedge pclk); #1;
    check({tag, ".addr"}, 32'(rom_addr), 32'(ea));
    @(posedge pclk);
    @(posedge pclk); #1;
    check({tag, ".rgb"}, 32'(rgb_out), 32'(er));
    check({tag, ".hcnt"}, 32'(hcount_out), 32'(h));
    check({tag, ".vcnt"}, 32'(vcount_out), 32'(v));
    hblnk_in = 1'b0;
  endtask

  logic [11:0] key_exp;

  initial begin
    // Reset with busy inputs: every output must stay 0
    hcount_in = 11'd321; vcount_in = 11'd123; hsync_in = 1'b1; vsync_in = 1'b1;
    hblnk_in = 1'b1; vblnk_in = 1'b1; rgb_in = 12'hFFF;
    rst = 1'b1;
    repeat (4) @(posedge pclk);
    #1;
    check("rst.addr", 32'(rom_addr), 32'd0);
    check("rst.rgb", 32'(rgb_out), 32'd0);
    check("rst.hcnt", 32'(hcount_out), 32'd0);
    check("rst.vcnt", 32'(vcount_out), 32'd0);
    check("rst.hs", 32'(hsync_out), 32'd0);
    check("rst.vs", 32'(vsync_out), 32'd0);
    check("rst.hb", 32'(hblnk_out), 32'd0);
    check("rst.vb", 32'(vblnk_out), 32'd0);
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rst = 1'b0;
    @(posedge pclk); #1;

    // Basic placement, rot 0 at (100,50)
    latch_frame(12'd100, 12'd50, 2'd0);
    px("r0_tl", 11'd100, 11'd50, 12'h111, 1'b0, 12'd0, rom_word(12'd0));
    px("r0_br", 11'd152, 11'd103, 12'h222, 1'b0, 12'd2861, rom_word(12'd2861));
    px("r0_out", 11'd153, 11'd50, 12'h333, 1'b0, 12'd0, 12'h333);

    // Blanked pixel inside the sprite is black
    px("blank", 11'd110, 11'd60, 12'hABC, 1'b1, 12'd540, 12'h000);

    // Sync pass-through with exactly 3 cycles of latency
    hsync_in = 1'b1; vsync_in = 1'b1;
    @(posedge pclk); #1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    @(posedge pclk); #1;
    check("sync.t2.hs", 32'(hsync_out), 32'd0);
    @(posedge pclk); #1;
    check("sync.t3.hs", 32'(hsync_out), 32'd1);
    check("sync.t3.vs", 32'(vsync_out), 32'd1);
    @(posedge pclk); #1;
    check("sync.t4.hs", 32'(hsync_out), 32'd0);

    // Rotation mapping at origin
    latch_frame(12'd0, 12'd0, 2'd2);
    px("r2_00", 11'd0, 11'd0, 12'h444, 1'b0, 12'd2861, rom_word(12'd2861));
    latch_frame(12'd0, 12'd0, 2'd1);
    px("r1_00", 11'd0, 11'd0, 12'h555, 1'b0, 12'd52, rom_word(12'd52));
    px("r1_530", 11'd53, 11'd0, 12'h556, 1'b0, 12'd2861, rom_word(12'd2861));
    px("r1_053", 11'd0, 11'd53, 12'h557, 1'b0, 12'd0, 12'h557);
    latch_frame(12'd0, 12'd0, 2'd3);
    px("r3_00", 11'd0, 11'd0, 12'h666, 1'b0, 12'd2809, rom_word(12'd2809));

    // Mid-frame xpos change has no effect until the next vblank edge
    latch_frame(12'd100, 12'd250, 2'd0);
    xpos = 12'd200;
    px("mid_old", 11'd100, 11'd300, 12'h777, 1'b0, 12'd2650, rom_word(12'd2650));
    px("mid_new", 11'd200, 11'd300, 12'h778, 1'b0, 12'd0, 12'h778);
    latch_frame(12'd200, 12'd250, 2'd0);
    px("next_frm", 11'd200, 11'd300, 12'h779, 1'b0, 12'd2650, rom_word(12'd2650));

    // Bottom-right clip: no wrap to left/top
    latch_frame(12'd780, 12'd580, 2'd0);
    px("clip_in", 11'd799, 11'd599, 12'h888, 1'b0, 12'd1026, rom_word(12'd1026));
    px("clip_l", 11'd20, 11'd580, 12'h889, 1'b0, 12'd0, 12'h889);
    px("clip_t", 11'd790, 11'd10, 12'h88A, 1'b0, 12'd0, 12'h88A);

    // Colour-key pixel (ROM[0xAAA] = 0xF0F at col 27, row 51)
`ifdef BUG_TRANSPARENT_EN
    key_exp = 12'h3C3;
`else
    key_exp = 12'hF0F;
`endif
    latch_frame(12'd0, 12'd0, 2'd0);
    px("key", 11'd27, 11'd51, 12'h3C3, 1'b0, 12'd2730, key_exp);

    // Mid-run reset clears the latches back to 0
    latch_frame(12'd400, 12'd400, 2'd2);
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    check("rst2.rgb", 32'(rgb_out), 32'd0);
    rst = 1'b0;
    px("post_rst", 11'd10, 11'd10, 12'h999, 1'b0, 12'd540, rom_word(12'd540));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
